oem_sort_stream: RTL and testbench

- Parametrised, streaming Batcher odd-even merge sorter for N unsigned lanes of DATA_W bits.
- Generalises the fixed 4×8-bit sorter wrapper: configurable width, lane count, pipelining and sort direction, with a valid/ready handshake and back-pressure.
- Sits between a producer presenting N-word vectors and a consumer, one vector per handshake.

---
 rtl/oem_sort_stream_pkg.sv | 81 ++++++++
 rtl/oem_sort_stream_if.sv | 30 +++
 rtl/oem_sort_stream_ce.sv | 21 ++
 rtl/oem_sort_stream.sv | 116 +++++++++++
 tb/tb_oem_sort_stream.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/oem_sort_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : oem_sort_pkg
// Purpose  : Batcher odd-even merge network tables for oem_sort_stream.
// Revision : 1.0
// ============================================================================
package oem_sort_pkg;

    localparam int MAX_N = 16;
    localparam int IDX_W = 4;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] lo;
        logic [IDX_W-1:0] hi;
    } ce_pair_t;

    typedef struct packed {
        logic             used;
        logic             is_lo;
        logic [IDX_W-1:0] partner;
    } lane_role_t;

    function automatic int num_stages(input int n);
        int l;
        l = $clog2(n);
        return (l * (l + 1)) / 2;
    endfunction

    // Each (p,k) iteration of Batcher's merge loop is one network stage; pairs
    // inside a stage are numbered in enumeration order.
    function automatic ce_pair_t ce_pair(input int n, input int stage, input int idx);
        ce_pair_t r;
        int       st;
        int       cnt;
        r  = '0;
        st = 0;
        for (int p = 1; p < n; p = p * 2) begin
            for (int k = p; k >= 1; k = k / 2) begin
                if (st == stage) begin
                    cnt = 0;
                    for (int j = k % p; j + k < n; j = j + 2 * k) begin
                        for (int i = 0; i < k; i++) begin
                            if ((i + j + k < n) && ((i + j) / (2 * p) == (i + j + k) / (2 * p))) begin
                                if (cnt == idx) begin
                                    r.valid = 1'b1;
                                    r.lo    = IDX_W'(i + j);
                                    r.hi    = IDX_W'(i + j + k);
                                end
                                cnt++;
                            end
                        end
                    end
                end
                st++;
            end
        end
        return r;
    endfunction

    function automatic lane_role_t lane_role(input int n, input int stage, input int lane);
        lane_role_t r;
        ce_pair_t   cp;
        r = '0;
        for (int q = 0; q < n / 2; q++) begin
            cp = ce_pair(n, stage, q);
            if (cp.valid && int'(cp.lo) == lane) begin
                r.used    = 1'b1;
                r.is_lo   = 1'b1;
                r.partner = cp.hi;
            end else if (cp.valid && int'(cp.hi) == lane) begin
                r.used    = 1'b1;
                r.is_lo   = 1'b0;
                r.partner = cp.lo;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/oem_sort_stream_if.sv
`default_nettype none
// ============================================================================
// Module   : oem_sort_stream_if
// Purpose  : Valid/ready vector stream in and sorted vector stream out.
// Revision : 1.0
// ============================================================================
interface oem_sort_stream_if #(
    parameter int DATA_W = 8,
    parameter int N      = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [N*DATA_W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [N*DATA_W-1:0] out_data;
    logic [DATA_W-1:0]   out_max;
    logic [DATA_W-1:0]   out_min;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_max, out_min
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_max, out_min
    );
endinterface
`default_nettype wire

// File: rtl/oem_sort_stream_ce.sv
`default_nettype none
// ============================================================================
// Module   : oem_ce
// Purpose  : Unsigned compare-exchange: lo gets the smaller, hi the larger.
// Revision : 1.0
// ============================================================================
module oem_ce #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);
    logic w_swap;

    assign w_swap = (a > b);
    assign lo     = w_swap ? b : a;
    assign hi     = w_swap ? a : b;
endmodule
`default_nettype wire

// File: rtl/oem_sort_stream.sv
`default_nettype none
// ============================================================================
// Module   : oem_sort_stream
// Purpose  : Streaming Batcher odd-even merge sorter with global-stall handshake.
// Revision : 1.0
// ============================================================================
module oem_sort_stream
    import oem_sort_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int N          = 4,
    parameter int PIPELINE   = 1,
    parameter int DESCENDING = 1
) (
    input  logic             clk,
    input  logic             rst,
    oem_sort_stream_if.slave bus
);
    localparam int c_stages = num_stages(N);

    logic              w_advance;
    logic              w_last_vld;
    logic [DATA_W-1:0] w_in      [N];
    logic [DATA_W-1:0] w_last    [N];
    logic [DATA_W-1:0] w_net_in  [c_stages][N];
    logic [DATA_W-1:0] w_net_out [c_stages][N];

    assign w_advance    = bus.out_ready | ~w_last_vld;
    assign bus.in_ready = w_advance;

    for (genvar l = 0; l < N; l++) begin : g_unpack
        assign w_in[l] = bus.in_data[l*DATA_W +: DATA_W];
    end

    assign w_net_in[0] = w_in;

    // The lo lane of each pair owns the CE instance and drives both outputs.
    for (genvar s = 0; s < c_stages; s++) begin : g_stage
        for (genvar l = 0; l < N; l++) begin : g_lane
            localparam lane_role_t c_role    = lane_role(N, s, l);
            localparam int         c_partner = int'(c_role.partner);
            if (!c_role.used) begin : g_pass
                assign w_net_out[s][l] = w_net_in[s][l];
            end else if (c_role.is_lo) begin : g_ce
                oem_ce #(.DATA_W(DATA_W)) u_ce (
                    .a  (w_net_in[s][l]),
                    .b  (w_net_in[s][c_partner]),
                    .lo (w_net_out[s][l]),
                    .hi (w_net_out[s][c_partner])
                );
            end
        end
    end

    if (PIPELINE != 0) begin : g_pipe
        logic [DATA_W-1:0] r_stg [c_stages][N];
        logic [c_stages-1:0] r_vld;

        for (genvar s = 1; s < c_stages; s++) begin : g_link
            assign w_net_in[s] = r_stg[s-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= '0;
                for (int s = 0; s < c_stages; s++)
                    for (int l = 0; l < N; l++)
                        r_stg[s][l] <= '0;
            end else if (w_advance) begin
                r_vld[0] <= bus.in_valid;
                for (int s = 1; s < c_stages; s++)
                    r_vld[s] <= r_vld[s-1];
                for (int s = 0; s < c_stages; s++)
                    r_stg[s] <= w_net_out[s];
            end
        end

        assign w_last     = r_stg[c_stages-1];
        assign w_last_vld = r_vld[c_stages-1];
    end else begin : g_comb
        logic [DATA_W-1:0] r_out [N];
        logic              r_vld;

        for (genvar s = 1; s < c_stages; s++) begin : g_link
            assign w_net_in[s] = w_net_out[s-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld <= 1'b0;
                for (int l = 0; l < N; l++)
                    r_out[l] <= '0;
            end else if (w_advance) begin
                r_vld <= bus.in_valid;
                r_out <= w_net_out[c_stages-1];
            end
        end

        assign w_last     = r_out;
        assign w_last_vld = r_vld;
    end

    // The network always leaves lane N-1 as the maximum; ascending-lane output reverses it.
    for (genvar l = 0; l < N; l++) begin : g_pack
        if (DESCENDING != 0) begin : g_keep
            assign bus.out_data[l*DATA_W +: DATA_W] = w_last[l];
        end else begin : g_rev
            assign bus.out_data[l*DATA_W +: DATA_W] = w_last[N-1-l];
        end
    end

    assign bus.out_valid = w_last_vld;
    assign bus.out_max   = w_last[N-1];
    assign bus.out_min   = w_last[0];
endmodule
`default_nettype wire

// File: tb/tb_oem_sort_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_oem_sort_stream
// Purpose  : Directed self-checking bench for oem_sort_stream (two configurations).
// Revision : 1.0
// ============================================================================
module tb_oem_sort_stream;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   got      = 0;
    logic rdy_ok;
    logic gap;
    logic [31:0]  exp_q [$];
    logic [127:0] vb;

    always #5 clk = ~clk;

    oem_sort_stream_if #(.DATA_W(8),  .N(4)) ifa ();
    oem_sort_stream_if #(.DATA_W(16), .N(8)) ifb ();

    oem_sort_stream #(.DATA_W(8), .N(4), .PIPELINE(1), .DESCENDING(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    oem_sort_stream #(.DATA_W(16), .N(8), .PIPELINE(0), .DESCENDING(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_sort(input logic [31:0] v);
        logic [7:0]  ln [4];
        logic [7:0]  t;
        logic [31:0] r;
        for (int i = 0; i < 4; i++) ln[i] = v[i*8 +: 8];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (ln[j] > ln[j+1]) begin
                    t = ln[j]; ln[j] = ln[j+1]; ln[j+1] = t;
                end
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = ln[i];
        return r;
    endfunction

    // One clock; handshakes on dut_a are sampled before the edge and scored after it.
    task automatic step();
        logic        acc, take, rs;
        logic [31:0] dout, din;
        #2;
        acc  = ifa.in_valid & ifa.in_ready;
        take = ifa.out_valid & ifa.out_ready;
        dout = ifa.out_data;
        din  = ifa.in_data;
        rs   = rst;
        @(posedge clk);
        #1;
        if (rs) begin
            exp_q.delete();
        end else begin
            if (take) begin
                if (exp_q.size() == 0) chk("spurious_out", take, 1'b0);
                else begin
                    chk("scoreboard", dout, exp_q.pop_front());
                    got++;
                end
            end
            if (acc) exp_q.push_back(ref_sort(din));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;
        @(posedge clk); #1;
        step(); step();
        chk("rst_a_valid", ifa.out_valid, 1'b0);
        chk("rst_a_data",  ifa.out_data, 32'h0);
        chk("rst_a_max",   ifa.out_max, 8'h0);
        chk("rst_a_min",   ifa.out_min, 8'h0);
        chk("rst_b_valid", ifb.out_valid, 1'b0);
        chk("rst_b_data",  ifb.out_data, 128'h0);
        rst = 1'b0;
        ifa.out_ready = 1'b0;
        step();
        chk("in_ready_after_rst", ifa.in_ready, 1'b1);
        ifa.out_ready = 1'b1;

        // Basic sort, latency 3
        ifa.in_data = 32'h8005F012; ifa.in_valid = 1'b1;
        step();
        ifa.in_valid = 1'b0; ifa.in_data = '0;
        chk("lat1_valid", ifa.out_valid, 1'b0);
        step();
        chk("lat2_valid", ifa.out_valid, 1'b0);
        step();
        chk("lat3_valid", ifa.out_valid, 1'b1);
        chk("basic_data", ifa.out_data, 32'hF0801205);
        chk("basic_max",  ifa.out_max, 8'hF0);
        chk("basic_min",  ifa.out_min, 8'h05);
        step();
        chk("basic_drop", ifa.out_valid, 1'b0);

        // Ties and extremes
        ifa.in_data = 32'h00FF00FF; ifa.in_valid = 1'b1;
        step();
        ifa.in_data = 32'h7A7A7A7A;
        step();
        ifa.in_valid = 1'b0;
        step();
        chk("tie_data", ifa.out_data, 32'hFFFF0000);
        chk("tie_max",  ifa.out_max, 8'hFF);
        chk("tie_min",  ifa.out_min, 8'h00);
        step();
        chk("same_data", ifa.out_data, 32'h7A7A7A7A);
        chk("same_max",  ifa.out_max, 8'h7A);
        chk("same_min",  ifa.out_min, 8'h7A);
        step();

        // Back-to-back streaming
        got = 0; rdy_ok = 1'b1; gap = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                ifa.in_valid = 1'b1;
                ifa.in_data  = $urandom;
            end else begin
                ifa.in_valid = 1'b0;
            end
            if (ifa.in_ready !== 1'b1) rdy_ok = 1'b0;
            step();
            if (c >= 2 && c <= 17 && ifa.out_valid !== 1'b1) gap = 1'b1;
        end
        chk("stream_count", got, 16);
        chk("stream_in_ready", rdy_ok, 1'b1);
        chk("stream_no_gap", gap, 1'b0);
        chk("stream_drained", exp_q.size(), 0);

        // Back-pressure with a full pipe plus one vector waiting at the input
        got = 0;
        ifa.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ifa.in_valid = 1'b1;
            ifa.in_data  = $urandom;
            step();
        end
        ifa.in_data = $urandom;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_in_ready", ifa.in_ready, 1'b0);
            chk("bp_valid",    ifa.out_valid, 1'b1);
            chk("bp_hold",     ifa.out_data, exp_q[0]);
        end
        ifa.out_ready = 1'b1;
        step();
        ifa.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("bp_count", got, 4);
        chk("bp_drained", exp_q.size(), 0);

        // Reset with two vectors in flight
        ifa.in_valid = 1'b1; ifa.in_data = $urandom;
        step();
        ifa.in_data = $urandom;
        step();
        ifa.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", ifa.out_valid, 1'b0);
        chk("midrst_data",  ifa.out_data, 32'h0);
        gap = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (ifa.out_valid !== 1'b0) gap = 1'b1;
        end
        chk("midrst_no_stale", gap, 1'b0);
        ifa.in_data = 32'h44AA0133; ifa.in_valid = 1'b1;
        step();
        ifa.in_valid = 1'b0;
        step(); step();
        chk("postrst_valid", ifa.out_valid, 1'b1);
        chk("postrst_data",  ifa.out_data, 32'hAA443301);
        step();

        // N=8, 16-bit, combinational network, ascending lanes
        vb = {16'd4, 16'd6, 16'd2, 16'd8, 16'd1, 16'd9, 16'd3, 16'd7};
        ifb.in_data = vb; ifb.in_valid = 1'b1;
        step();
        ifb.in_valid = 1'b0;
        chk("b_valid", ifb.out_valid, 1'b1);
        chk("b_data",  ifb.out_data, {16'd1, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd8, 16'd9});
        chk("b_max",   ifb.out_max, 16'd9);
        chk("b_min",   ifb.out_min, 16'd1);
        ifb.out_ready = 1'b0;
        step();
        chk("b_stall_ready", ifb.in_ready, 1'b0);
        chk("b_stall_hold",  ifb.out_data, {16'd1, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd8, 16'd9});
        ifb.out_ready = 1'b1;
        step();
        chk("b_drop", ifb.out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
